// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared types and constants for the divider datapath blocks
// Contents: state_t (IDLE, MUL, DONE), DIV_WIDTH default operand width, clog2 counter-width helper.
package divider_pkg;

    localparam int DIV_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to hold values 0 .. value-1; never returns less than 1.
    function automatic int clog2(input int value);
        int bits;
        int v;
        bits = 0;
        v    = value - 1;
        while (v > 0) begin
            bits = bits + 1;
            v    = v >> 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/dividend_reconstructor_recon_adder.sv
// rtl/dividend_reconstructor_recon_adder.sv - ripple-carry adder built from full-adder cells, carry-in 0
// Ports: a, b (N-bit addends), sum (N-bit result, carry-out discarded; modulo 2^N).
module recon_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum
);

    logic [N-1:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum[i] = a[i] ^ b[i] ^ carry[i];
        // The carry out of the top cell is dropped: arithmetic is modulo 2^N.
        if (i < N - 1) begin : g_carry
            assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

endmodule

// File: rtl/dividend_reconstructor.sv
// rtl/dividend_reconstructor.sv - shift-and-add reconstruction D = Q*M + R (inverse of the divider)
// Ports: clk, rst_n (sync, active low); in_valid/in_ready with Q, M, R operands;
//        out_valid/out_ready with D (2*WIDTH bits).
// Optional macro RECON_CHECK_EN adds input expected and output mismatch (D != expected while out_valid).
module dividend_reconstructor
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     Q,
    input  logic [WIDTH-1:0]     M,
    input  logic [WIDTH-1:0]     R,
`ifdef RECON_CHECK_EN
    input  logic [2*WIDTH-1:0]   expected,
    output logic                 mismatch,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   D
);

    localparam int DW = 2 * WIDTH;
    localparam int CW = clog2(WIDTH + 1);

    state_t          state_q,   state_d;
    logic [DW-1:0]   mcand_q,   mcand_d;
    logic [WIDTH-1:0] q_shift_q, q_shift_d;
    logic [DW-1:0]   acc_q,     acc_d;
    logic [CW-1:0]   cnt_q,     cnt_d;
`ifdef RECON_CHECK_EN
    logic [DW-1:0]   exp_q,     exp_d;
    logic            mismatch_q, mismatch_d;
`endif

    logic [DW-1:0]   add_b;
    logic [DW-1:0]   sum;

    // Partial product for this iteration: the shifted multiplicand or nothing.
    assign add_b = q_shift_q[0] ? mcand_q : '0;

    recon_adder #(
        .N (DW)
    ) u_adder (
        .a   (acc_q),
        .b   (add_b),
        .sum (sum)
    );

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        q_shift_d = q_shift_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
`ifdef RECON_CHECK_EN
        exp_d      = exp_q;
        mismatch_d = mismatch_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d   = {{WIDTH{1'b0}}, M};
                    q_shift_d = Q;
                    // Seeding the accumulator with R folds the "+ R" into the multiply.
                    acc_d     = {{WIDTH{1'b0}}, R};
                    cnt_d     = '0;
`ifdef RECON_CHECK_EN
                    exp_d     = expected;
`endif
                    state_d   = MUL;
                end
            end
            MUL: begin
                acc_d     = sum;
                mcand_d   = mcand_q << 1;
                q_shift_d = q_shift_q >> 1;
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
`ifdef RECON_CHECK_EN
                    // Compare against the final accumulator value being written this edge.
                    mismatch_d = (sum != exp_q);
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
`ifdef RECON_CHECK_EN
                    mismatch_d = 1'b0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            q_shift_q <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
`ifdef RECON_CHECK_EN
            exp_q      <= '0;
            mismatch_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            q_shift_q <= q_shift_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
`ifdef RECON_CHECK_EN
            exp_q      <= exp_d;
            mismatch_q <= mismatch_d;
`endif
        end
    end

    // All outputs come straight from registers.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign D         = acc_q;
`ifdef RECON_CHECK_EN
    assign mismatch  = mismatch_q;
`endif

endmodule

// File: tb/tb_dividend_reconstructor.sv
// tb/tb_dividend_reconstructor.sv - self-checking bench for dividend_reconstructor
module tb_dividend_reconstructor;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] M;
    logic [WIDTH-1:0] R;
    logic             out_valid;
    logic             out_ready;
    logic [2*WIDTH-1:0] D;
`ifdef RECON_CHECK_EN
    logic [2*WIDTH-1:0] expected;
    logic               mismatch;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [WIDTH-1:0]   q;
        logic [WIDTH-1:0]   m;
        logic [WIDTH-1:0]   r;
        logic [2*WIDTH-1:0] expv;
        logic [2*WIDTH-1:0] d;
        logic               mism;
        int                 hold;
        logic               early;
    } vec_t;

    dividend_reconstructor #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Q         (Q),
        .M         (M),
        .R         (R),
`ifdef RECON_CHECK_EN
        .expected  (expected),
        .mismatch  (mismatch),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // One full transaction: accept, wait for the result, optional backpressure, handshake.
    task automatic run_op(input vec_t v, input bit scramble);
        int lat;
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        Q         = v.q;
        M         = v.m;
        R         = v.r;
`ifdef RECON_CHECK_EN
        expected  = v.expv;
`endif
        in_valid  = 1'b1;
        out_ready = v.early;
        tick();
        in_valid = 1'b0;
        chk("in_ready_busy", 64'(in_ready), 64'd0);
        lat = 0;
        while (!out_valid && lat < 3 * WIDTH) begin
            if (scramble) begin
                Q        = WIDTH'($urandom);
                M        = WIDTH'($urandom);
                R        = WIDTH'($urandom);
                in_valid = 1'($urandom_range(0, 1));
`ifdef RECON_CHECK_EN
                expected = (2*WIDTH)'($urandom);
`endif
            end
            tick();
            lat++;
        end
        in_valid = 1'b0;
        chk("latency", 64'(lat), 64'(WIDTH));
        chk("out_valid", 64'(out_valid), 64'd1);
        chk("D", 64'(D), 64'(v.d));
`ifdef RECON_CHECK_EN
        chk("mismatch", 64'(mismatch), 64'(v.mism));
`endif
        if (!v.early) begin
            for (int i = 0; i < v.hold; i++) begin
                tick();
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_D", 64'(D), 64'(v.d));
                chk("hold_in_ready", 64'(in_ready), 64'd0);
`ifdef RECON_CHECK_EN
                chk("hold_mismatch", 64'(mismatch), 64'(v.mism));
`endif
            end
            out_ready = 1'b1;
        end
        tick();
        out_ready = 1'b0;
        chk("post_valid", 64'(out_valid), 64'd0);
        chk("post_in_ready", 64'(in_ready), 64'd1);
`ifdef RECON_CHECK_EN
        chk("post_mismatch", 64'(mismatch), 64'd0);
`endif
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_D"}, 64'(D), 64'd0);
`ifdef RECON_CHECK_EN
        chk({tag, "_mismatch"}, 64'(mismatch), 64'd0);
`endif
    endtask

    initial begin
        vec_t vecs[8];
        vec_t rv;
        int   model;

        //         q      m      r      expected  d        mism  hold early
        vecs[0] = '{4'd3,  4'd5,  4'd2,  8'd17,    8'd17,   1'b0, 0,   1'b0};
        vecs[1] = '{4'd15, 4'd15, 4'd14, 8'd239,   8'd239,  1'b0, 1,   1'b0};
        vecs[2] = '{4'd9,  4'd0,  4'd7,  8'd7,     8'd7,    1'b0, 0,   1'b0};
        vecs[3] = '{4'd0,  4'd11, 4'd3,  8'd3,     8'd3,    1'b0, 0,   1'b0};
        vecs[4] = '{4'd5,  4'd7,  4'd4,  8'd39,    8'd39,   1'b0, 6,   1'b0};
        vecs[5] = '{4'd2,  4'd6,  4'd1,  8'd13,    8'd13,   1'b0, 0,   1'b0};
        vecs[6] = '{4'd4,  4'd4,  4'd1,  8'd18,    8'd17,   1'b1, 2,   1'b0};
        vecs[7] = '{4'd7,  4'd9,  4'd5,  8'd68,    8'd68,   1'b0, 0,   1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        Q         = '0;
        M         = '0;
        R         = '0;
`ifdef RECON_CHECK_EN
        expected  = '0;
`endif
        tick();
        tick();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i], 1'b0);
        end

        // Reset while the multiply is in progress: no result may ever appear.
        Q        = 4'd13;
        M        = 4'd12;
        R        = 4'd11;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        chk_reset_outputs("mid_mul");
        rst_n = 1'b1;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            tick();
            chk("no_pulse", 64'(out_valid), 64'd0);
        end
        run_op(vecs[0], 1'b0);

        // Reset while the result is being held.
        Q        = 4'd6;
        M        = 4'd6;
        R        = 4'd6;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < WIDTH + 1; i++) tick();
        rst_n = 1'b0;
        tick();
        chk_reset_outputs("mid_done");
        rst_n = 1'b1;
        tick();
        chk("after_done_reset_valid", 64'(out_valid), 64'd0);

        // Randomised operations against D = Q*M + R.
        for (int n = 0; n < 40; n++) begin
            rv.q     = WIDTH'($urandom);
            rv.m     = WIDTH'($urandom);
            rv.r     = WIDTH'($urandom);
            model    = int'(rv.q) * int'(rv.m) + int'(rv.r);
            rv.d     = (2*WIDTH)'(model);
            rv.expv  = ($urandom_range(0, 3) == 0) ? (2*WIDTH)'($urandom) : rv.d;
            rv.mism  = (int'(rv.expv) != model);
            rv.hold  = int'($urandom_range(0, 3));
            rv.early = 1'($urandom_range(0, 1));
            run_op(rv, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
